// File: rtl/uart_core.sv
// uart_core: full-duplex 8N1 UART, 16x oversampled RX with mid-bit sampling.
// Define UART_PARITY_EN for an even-parity bit per frame plus the rx_parity_err output.
//
// state | meaning
// IDLE  | TX: waiting for a loaded byte and tx_enable; RX: hunting for a start bit
// START | start bit on the line
// DATA  | data bits d0..d7 (and the parity bit when enabled)
// STOP  | stop bit
module uart_core #(
   parameter int unsigned BAUD_DIV = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ld_tx_data,
   input  logic [7:0] tx_data,
   input  logic       tx_enable,
   output logic       tx_out,
   output logic       tx_empty,
   input  logic       uld_rx_data,
   output logic [7:0] rx_data,
   input  logic       rx_enable,
   input  logic       rx_in,
   output logic       rx_empty,
   output logic       rx_overrun,
`ifdef UART_PARITY_EN
   output logic       rx_parity_err,
`endif
   output logic       rx_frame_err
);

`ifdef UART_PARITY_EN
   localparam int unsigned NBITS = 9;
`else
   localparam int unsigned NBITS = 8;
`endif
   localparam logic [15:0] DIV_TC = 16'(BAUD_DIV - 1);
   localparam logic [3:0]  RX_MID = 4'd8;   // sample count 7 on a down-counter loaded with 15

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [15:0] div_cnt;
   logic        tick;

   assign tick = (div_cnt == 16'd0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    div_cnt <= DIV_TC;
      else if (tick) div_cnt <= DIV_TC;
      else           div_cnt <= div_cnt - 16'd1;
   end

   state_t           tx_state, tx_nxt;
   logic [3:0]       tx_sub;
   logic [3:0]       tx_bit;
   logic [7:0]       tx_hold;
   logic [NBITS+1:0] tx_shift;
   logic [NBITS+1:0] tx_frame;
   logic             tx_bit_end;

`ifdef UART_PARITY_EN
   assign tx_frame = {1'b1, ^tx_hold, tx_hold, 1'b0};
`else
   assign tx_frame = {1'b1, tx_hold, 1'b0};
`endif
   assign tx_bit_end = tick && (tx_sub == 4'd0);
   assign tx_out     = tx_shift[0];

   always_comb begin
      tx_nxt = tx_state;
      case (tx_state)
         IDLE:    if (tick && !tx_empty && tx_enable) tx_nxt = START;
         START:   if (tx_bit_end) tx_nxt = DATA;
         DATA:    if (tx_bit_end && (tx_bit == 4'd0)) tx_nxt = STOP;
         STOP:    if (tx_bit_end) tx_nxt = IDLE;
         default: tx_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) tx_state <= IDLE;
      else        tx_state <= tx_nxt;
   end

   // The whole frame lives in tx_shift so tx_out comes straight from a flop.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_sub   <= 4'd0;
         tx_bit   <= 4'd0;
         tx_shift <= '1;
         tx_hold  <= 8'd0;
         tx_empty <= 1'b1;
      end else begin
         if ((tx_state == IDLE) && (tx_nxt == START)) begin
            tx_shift <= tx_frame;
            tx_sub   <= 4'd15;
            tx_bit   <= 4'(NBITS - 1);
         end else if ((tx_state != IDLE) && tick) begin
            if (tx_sub == 4'd0) begin
               tx_sub   <= 4'd15;
               tx_shift <= {1'b1, tx_shift[NBITS+1:1]};
               if (tx_state == DATA) tx_bit <= tx_bit - 4'd1;
            end else begin
               tx_sub <= tx_sub - 4'd1;
            end
         end
         if ((tx_state == STOP) && (tx_nxt == IDLE)) begin
            tx_empty <= 1'b1;
         end else if (ld_tx_data && tx_empty) begin
            tx_hold  <= tx_data;
            tx_empty <= 1'b0;
         end
      end
   end

   state_t           rx_state, rx_nxt;
   logic             rx_meta, rx_sync;
   logic [3:0]       rx_cnt;
   logic [3:0]       rx_bit;
   logic [NBITS-1:0] rx_shift;
   logic [7:0]       rx_buf;
   logic             rx_mid, rx_done, rx_unload;

   assign rx_mid    = tick && (rx_cnt == RX_MID);
   assign rx_done   = (rx_state == STOP) && rx_mid && rx_enable;
   assign rx_unload = uld_rx_data && !rx_empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) {rx_meta, rx_sync} <= 2'b11;
      else        {rx_meta, rx_sync} <= {rx_in, rx_meta};
   end

   always_comb begin
      rx_nxt = rx_state;
      if (!rx_enable) begin
         rx_nxt = IDLE;
      end else begin
         case (rx_state)
            IDLE:    if (tick && !rx_sync) rx_nxt = START;
            START:   if (rx_mid) rx_nxt = rx_sync ? IDLE : DATA;
            DATA:    if (rx_mid && (rx_bit == 4'd0)) rx_nxt = STOP;
            STOP:    if (rx_mid) rx_nxt = IDLE;
            default: rx_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rx_state <= IDLE;
      else        rx_state <= rx_nxt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_cnt   <= 4'd15;
         rx_bit   <= 4'd0;
         rx_shift <= '0;
      end else if (rx_state == IDLE) begin
         rx_cnt <= 4'd15;
         rx_bit <= 4'(NBITS - 1);
      end else if (tick) begin
         rx_cnt <= rx_cnt - 4'd1;
         if ((rx_state == DATA) && (rx_cnt == RX_MID)) begin
            rx_shift <= {rx_sync, rx_shift[NBITS-1:1]};
            rx_bit   <= rx_bit - 4'd1;
         end
      end
   end

   // A completing byte wins over a same-cycle unload for the flags it sets.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_buf        <= 8'd0;
         rx_data       <= 8'd0;
         rx_empty      <= 1'b1;
         rx_overrun    <= 1'b0;
         rx_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
         rx_parity_err <= 1'b0;
`endif
      end else begin
         if (rx_unload) begin
            rx_data       <= rx_buf;
            rx_empty      <= 1'b1;
            rx_overrun    <= 1'b0;
            rx_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
         end
         if (rx_done) begin
            rx_buf       <= rx_shift[7:0];
            rx_empty     <= 1'b0;
            rx_frame_err <= !rx_sync;
            if (!rx_empty && !rx_unload) rx_overrun <= 1'b1;
`ifdef UART_PARITY_EN
            rx_parity_err <= ^rx_shift;
`endif
         end
      end
   end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core at BAUD_DIV=1: a cycle model of the serial
// frame and receive handshake is compared against the DUT on every falling edge.
module tb_uart_core;

`ifdef UART_PARITY_EN
   localparam int NB = 11;
   localparam bit PAR_EN = 1'b1;
`else
   localparam int NB = 10;
   localparam bit PAR_EN = 1'b0;
`endif
   // start-bit midpoint (8 clk) + remaining bits + 2 sync flops + 1 clk to leave IDLE
   localparam int RX_LAT = 16 * NB - 5;

   logic       clk, reset;
   logic       ld_tx_data, tx_enable, tx_out, tx_empty;
   logic [7:0] tx_data, rx_data;
   logic       uld_rx_data, rx_enable, rx_in, rx_empty, rx_overrun, rx_frame_err;
`ifdef UART_PARITY_EN
   logic       rx_parity_err;
`endif
   logic       rx_drv, loop_en;

   assign rx_in = loop_en ? tx_out : rx_drv;

   uart_core #(.BAUD_DIV(1)) dut (
      .clk          (clk),
      .reset        (reset),
      .ld_tx_data   (ld_tx_data),
      .tx_data      (tx_data),
      .tx_enable    (tx_enable),
      .tx_out       (tx_out),
      .tx_empty     (tx_empty),
      .uld_rx_data  (uld_rx_data),
      .rx_data      (rx_data),
      .rx_enable    (rx_enable),
      .rx_in        (rx_in),
      .rx_empty     (rx_empty),
      .rx_overrun   (rx_overrun),
`ifdef UART_PARITY_EN
      .rx_parity_err(rx_parity_err),
`endif
      .rx_frame_err (rx_frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         v;
      logic [7:0] b;
      logic       fe;
      logic       pe;
   } ev_t;

   int         checks, errors, cyc;
   bit         m_tx_empty, m_pend, m_busy;
   int         m_start;
   logic [7:0] m_byte, m_buf, m_rx_data;
   bit         m_rx_empty, m_ovr, m_ferr;
`ifdef UART_PARITY_EN
   bit         m_perr;
`endif
   ev_t        q[$];
   int         inj_cnt, inj_seen;
   logic [7:0] inj_byte;
   logic       inj_stop, inj_par;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic bound_fail(input string name, input bit ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: event did not occur within its cycle budget (cycle %0d)", name, cyc);
      end
   endtask

   // Frame bit i of byte b: start, d0..d7 LSB first, optional even parity, stop.
   function automatic logic frame_bit(input logic [7:0] b, input int i);
      if (i == 0) return 1'b0;
      if (i <= 8) return b[3'(i - 1)];
      if (PAR_EN && (i == 9)) return ^b;
      return 1'b1;
   endfunction

   task automatic model_reset();
      m_tx_empty = 1'b1; m_pend = 1'b0; m_busy = 1'b0; m_start = 0; m_byte = 8'h00;
      m_buf = 8'h00; m_rx_data = 8'h00; m_rx_empty = 1'b1; m_ovr = 1'b0; m_ferr = 1'b0;
`ifdef UART_PARITY_EN
      m_perr = 1'b0;
`endif
      q.delete();
   endtask

   // Compare current outputs to the model, then advance the model by the
   // inputs that the next rising edge will sample.
   task automatic checker_loop();
      ev_t  e;
      logic exp_tx;
      bit   unl, was_empty;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) model_reset();
         if (inj_cnt != inj_seen) begin
            inj_seen = inj_cnt;
            e.v = cyc + RX_LAT; e.b = inj_byte; e.fe = !inj_stop; e.pe = (inj_par != ^inj_byte);
            q.push_back(e);
         end
         exp_tx = 1'b1;
         if (m_busy && (cyc >= m_start) && (cyc < m_start + 16 * NB))
            exp_tx = frame_bit(m_byte, (cyc - m_start) / 16);
         chk("tx_out", 8'(tx_out), 8'(exp_tx));
         chk("tx_empty", 8'(tx_empty), 8'(m_tx_empty));
         chk("rx_empty", 8'(rx_empty), 8'(m_rx_empty));
         chk("rx_data", rx_data, m_rx_data);
         chk("rx_overrun", 8'(rx_overrun), 8'(m_ovr));
         chk("rx_frame_err", 8'(rx_frame_err), 8'(m_ferr));
`ifdef UART_PARITY_EN
         chk("rx_parity_err", 8'(rx_parity_err), 8'(m_perr));
`endif
         if (reset) begin
            if (m_pend && tx_enable) begin
               m_pend = 1'b0; m_busy = 1'b1; m_start = cyc + 1;
               if (loop_en) begin
                  e.v = m_start + RX_LAT; e.b = m_byte; e.fe = 1'b0; e.pe = 1'b0;
                  q.push_back(e);
               end
            end
            if (ld_tx_data && m_tx_empty) begin
               m_tx_empty = 1'b0; m_pend = 1'b1; m_byte = tx_data;
            end
            if (m_busy && (cyc + 1 == m_start + 16 * NB)) begin
               m_busy = 1'b0; m_tx_empty = 1'b1;
            end
            unl = uld_rx_data && !m_rx_empty;
            was_empty = m_rx_empty;
            if (unl) begin
               m_rx_data = m_buf; m_rx_empty = 1'b1; m_ovr = 1'b0; m_ferr = 1'b0;
`ifdef UART_PARITY_EN
               m_perr = 1'b0;
`endif
            end
            if ((q.size() > 0) && (q[0].v == cyc + 1)) begin
               e = q.pop_front();
               m_buf = e.b; m_rx_empty = 1'b0; m_ferr = e.fe;
`ifdef UART_PARITY_EN
               m_perr = e.pe;
`endif
               if (!was_empty && !unl) m_ovr = 1'b1;
            end
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_byte(input logic [7:0] b);
      int n = 0;
      while (!tx_empty && (n < 400)) begin step(); n++; end
      bound_fail("tx_empty_wait", tx_empty);
      tx_data = b; ld_tx_data = 1'b1;
      step();
      ld_tx_data = 1'b0;
   endtask

   task automatic wait_tx_fall();
      int n = 0;
      while (tx_out && (n < 400)) begin @(negedge clk); n++; end
      bound_fail("tx_start_wait", !tx_out);
   endtask

   task automatic wait_rx_full();
      int n = 0;
      while (rx_empty && (n < 400)) begin @(negedge clk); n++; end
      bound_fail("rx_full_wait", !rx_empty);
   endtask

   task automatic unload_expect(input string name, input logic [7:0] b);
      step();
      uld_rx_data = 1'b1;
      step();
      uld_rx_data = 1'b0;
      @(negedge clk);
      chk(name, rx_data, b);
   endtask

   task automatic drive_frame(input logic [7:0] b, input logic stop, input logic par);
      step();
      inj_byte = b; inj_stop = stop; inj_par = par;
      rx_drv = 1'b0; inj_cnt++;
      repeat (16) step();
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         repeat (16) step();
      end
      if (PAR_EN) begin
         rx_drv = par;
         repeat (16) step();
      end
      rx_drv = stop;
      repeat (16) step();
      rx_drv = 1'b1;
   endtask

   initial begin
      reset = 1'b1; ld_tx_data = 1'b0; tx_data = 8'h00; tx_enable = 1'b1;
      uld_rx_data = 1'b0; rx_enable = 1'b1; rx_drv = 1'b1; loop_en = 1'b1;
      inj_cnt = 0; inj_seen = 0; inj_byte = 8'h00; inj_stop = 1'b1; inj_par = 1'b0;
      cyc = 0; checks = 0; errors = 0;
      model_reset();
      #1 reset = 1'b0;
      fork
         checker_loop();
      join_none

      repeat (25) @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_tx_out", 8'(tx_out), 8'h01);
      chk("rst_tx_empty", 8'(tx_empty), 8'h01);
      chk("rst_rx_empty", 8'(rx_empty), 8'h01);
      chk("rst_rx_data", rx_data, 8'h00);

      // 0x55: pin start, d0, d1 and stop at their bit midpoints
      step();
      load_byte(8'h55);
      wait_tx_fall();
      repeat (8) @(negedge clk);
      chk("lit_start_bit", 8'(tx_out), 8'h00);
      repeat (16) @(negedge clk);
      chk("lit_0x55_d0", 8'(tx_out), 8'h01);
      repeat (16) @(negedge clk);
      chk("lit_0x55_d1", 8'(tx_out), 8'h00);
      repeat (16 * (NB - 3)) @(negedge clk);
      chk("lit_stop_bit", 8'(tx_out), 8'h01);
      wait_rx_full();
      unload_expect("loop_0x55", 8'h55);

      // 0x41 loaded while tx_enable is low: the byte must wait
      tx_enable = 1'b0;
      load_byte(8'h41);
      repeat (30) step();
      chk("hold_tx_out", 8'(tx_out), 8'h01);
      tx_enable = 1'b1;
      wait_rx_full();
      unload_expect("loop_0x41", 8'h41);

      load_byte(8'h7D);
      wait_rx_full();
      unload_expect("loop_0x7D", 8'h7D);

      load_byte(8'h12);
      load_byte(8'h34);
      repeat (200) step();
      chk("ovr_set", 8'(rx_overrun), 8'h01);
      unload_expect("ovr_data", 8'h34);
      chk("ovr_clear", 8'(rx_overrun), 8'h00);

      loop_en = 1'b0;
      step();
      rx_drv = 1'b0;
      repeat (5) step();
      rx_drv = 1'b1;
      repeat (40) step();
      chk("glitch_rx_empty", 8'(rx_empty), 8'h01);

      drive_frame(8'hA5, 1'b0, 1'b0);
      repeat (40) step();
      chk("ferr_rx_empty", 8'(rx_empty), 8'h00);
      chk("ferr_set", 8'(rx_frame_err), 8'h01);
      unload_expect("ferr_data", 8'hA5);
      chk("ferr_clear", 8'(rx_frame_err), 8'h00);

      loop_en = 1'b1;
      step();
      load_byte(8'hC3);
      wait_tx_fall();
      repeat (72) @(negedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("midrst_tx_out", 8'(tx_out), 8'h01);
      chk("midrst_tx_empty", 8'(tx_empty), 8'h01);
      repeat (5) step();
      reset = 1'b1;
      repeat (200) step();
      chk("midrst_no_byte", 8'(rx_empty), 8'h01);
      load_byte(8'h3C);
      wait_rx_full();
      unload_expect("loop_0x3C", 8'h3C);

`ifdef UART_PARITY_EN
      load_byte(8'h07);
      wait_tx_fall();
      repeat (16 * 9 + 8) @(negedge clk);
      chk("lit_parity_0x07", 8'(tx_out), 8'h01);
      wait_rx_full();
      chk("perr_good", 8'(rx_parity_err), 8'h00);
      unload_expect("par_loop_0x07", 8'h07);
      loop_en = 1'b0;
      drive_frame(8'h07, 1'b1, 1'b0);
      wait_rx_full();
      chk("perr_bad", 8'(rx_parity_err), 8'h01);
      unload_expect("par_bad_data", 8'h07);
      loop_en = 1'b1;
`endif

      repeat (20) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Full-duplex 8N1 UART with independent TX and RX paths, running on a single system clock.
- An internal divider produces a 16x-oversample tick. TX shifts one bit every 16 ticks; RX samples at 16x and uses mid-bit sampling.
- Sits between FPGA-internal logic, which uses load/unload handshakes, and a two-wire serial line with no flow control.

Parameters:
- BAUD_DIV, 1: clk cycles per oversample tick. Tick rate = 16 x baud rate. Legal range 1..65535.

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  asynchronous, active-low reset
- ld_tx_data  in  1  load pulse; accepted only when tx_empty=1
- tx_data  in  8  byte to transmit
- tx_enable  in  1  allow a new frame to start
- tx_out  out  1  serial output; idles high
- tx_empty  out  1  1 = TX holding register free
- uld_rx_data  in  1  unload request; copies the received byte to rx_data
- rx_data  out  8  last unloaded byte
- rx_enable  in  1  enable the receiver
- rx_in  in  1  serial input; asynchronous
- rx_empty  out  1  0 = received byte waiting
- rx_overrun  out  1  a byte was overwritten before it was unloaded
- rx_frame_err  out  1  stop bit sampled low

Behaviour:

Reset (reset=0, any time, asynchronous):
- tx_out=1, tx_empty=1, rx_empty=1, rx_data=0, rx_overrun=0, rx_frame_err=0.
- All counters and FSMs go to IDLE. A frame in flight is abandoned.

Tick:
- A counter runs 0..BAUD_DIV-1; tick is asserted in the cycle where counter = BAUD_DIV-1.
- With BAUD_DIV=1, tick is high every cycle.

TX FSM (IDLE, START, DATA, STOP):
- A bit period is 16 ticks.
- Load: ld_tx_data=1 with tx_empty=1 latches tx_data; tx_empty drops on the next clk edge.
- ld_tx_data while tx_empty=0 is ignored.
- Frame start: IDLE -> START on the first tick after the load, only if tx_enable=1. If tx_enable=0 the byte is held until it rises.
- Frame: start bit (0), then d0..d7 LSB first, then stop bit (1); each bit lasts 16 ticks.
- tx_enable is checked only at frame start. Deasserting it mid-frame does not stop the frame.
- Completion: tx_empty returns to 1 at the end of the stop bit, in the same cycle the FSM returns to IDLE.
- Back-to-back loads therefore give frames separated by no idle time beyond one tick.

RX FSM (IDLE, START, DATA, STOP):
- rx_in passes through a 2-flop synchroniser before use.
- On a tick in IDLE with rx_enable=1 and synced rx=0: enter START and clear the sample counter.
- Start bit: sampled at sample count 7. If it reads 1, treat as a false start and return to IDLE.
- Data: each of d0..d7 is sampled at count 7 of its 16-tick bit and shifted into rx_reg LSB first.
- Stop bit: sampled at count 7.
  - rx_frame_err = NOT(sampled stop bit).
  - The byte is accepted regardless of the stop-bit value.
  - rx_empty goes to 0.
  - FSM returns to IDLE immediately at the stop-bit midpoint.
- Overrun: if rx_empty=0 when a new byte completes, rx_reg is overwritten and rx_overrun=1.
- Unload: uld_rx_data=1 with rx_empty=0 gives, on the next edge:
  - rx_data <= rx_reg, rx_empty <= 1;
  - rx_overrun and rx_frame_err cleared.
- Unload with rx_empty=1 has no effect.
- Unload and byte completion in the same cycle:
  - rx_data gets the old byte;
  - the new byte sets rx_empty=0;
  - rx_overrun is not set.
- rx_enable=0 mid-frame aborts to IDLE with no byte stored.

Timing:
- Loopback latency, measured from the tx_out falling edge to rx_empty=0: 9.5 bit periods plus 2-3 clk of synchroniser delay.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined:
  - TX inserts an even-parity bit (XOR of d0..d7) between d7 and the stop bit. Frame length is 11 bits.
  - RX samples that bit and adds output port rx_parity_err (1 bit).
  - rx_parity_err is set on mismatch when the byte completes and cleared on unload.
- Undefined:
  - 10-bit 8N1 frame.
  - Port rx_parity_err is absent.

Test Plan:

All scenarios use BAUD_DIV=1 with tx_out looped back to rx_in.
- Reset low for 25 clk, then high -> tx_out=1, tx_empty=1, rx_empty=1, rx_data=0x00.
- Loopback: load 0x55, unload on rx_empty=0; repeat for 0x41 and 0x7D.
  - rx_data equals each byte in turn.
  - tx_out bits match the frame LSB first; each bit is 16 clk wide.
  - rx_overrun=0 and rx_frame_err=0 throughout.
- Send 0x12 then 0x34 without unloading -> rx_overrun=1. Unload -> rx_data=0x34, rx_overrun=0.
- Drive rx_in directly:
  - a 5-clk low glitch -> rx_empty stays 1;
  - a frame 0xA5 with stop bit = 0 -> rx_empty=0, rx_frame_err=1; after unload rx_data=0xA5.
- Assert reset mid-frame at bit d3 -> tx_out=1 and tx_empty=1 immediately, no byte received. A following 0x3C loopback succeeds.
- With UART_PARITY_EN: loopback 0x07 -> parity bit 1, rx_parity_err=0. Force the parity bit to 0 on rx_in -> rx_parity_err=1.
